// File: rtl/mips_trace_buffer_if.sv
// Trace read port between mips_trace_buffer and its UART/LED readout stage.
// master drives the entry and RD_VALID; slave returns RD_READY.
interface mips_trace_buffer_if;
    logic        RD_VALID;
    logic        RD_READY;
    logic [31:0] RD_PC;
    logic [31:0] RD_DATA;
    logic        RD_LAST;

    modport master (output RD_VALID, output RD_PC, output RD_DATA, output RD_LAST,
                    input  RD_READY);
    modport slave  (input  RD_VALID, input  RD_PC, input  RD_DATA, input  RD_LAST,
                    output RD_READY);
endinterface

// File: rtl/mips_trace_buffer.sv
// Trigger-started (PC, Result) trace capture for the single-cycle MIPS core, drained over a valid/ready port.
// Define TRACE_DEDUP_EN to drop capture samples identical to the last written entry.
module mips_trace_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         ADDRESS,
    input  logic [31:0]         DATA,
    input  logic [31:0]         TRIG_ADDR,
    input  logic                ARM,
    input  logic                STOP,
    mips_trace_buffer_if.master rd,
    output logic [1:0]          STATE,
    output logic [AW:0]         COUNT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DRAIN   = 2'b11
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    state_t        state, state_d;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   sample;
    logic          wr_en, clr, rd_valid, rd_acc, dup;

    assign sample   = {ADDRESS, DATA};
    assign rd_valid = (state == S_DRAIN) && (count != '0);
    assign rd_acc   = rd_valid && rd.RD_READY;

`ifdef TRACE_DEDUP_EN
    logic [63:0] last_q;

    // Mirror of the most recent write, so the comparison never needs an array read port.
    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            last_q <= sample;
        end
    end

    assign dup = (sample == last_q);
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        wr_en   = 1'b0;
        clr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ARM) begin
                    clr     = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (ADDRESS == TRIG_ADDR) begin
                    wr_en   = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (STOP) begin
                    state_d = S_DRAIN;
                end else if (!dup) begin
                    wr_en = 1'b1;
                    if (wr_ptr == PTR_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count == '0 || (rd_acc && count == CNT_ONE)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            mem[wr_ptr] <= sample;
        end
    end

    assign rd.RD_VALID = rd_valid;
    assign rd.RD_PC    = rd_valid ? mem[rd_ptr][63:32] : '0;
    assign rd.RD_DATA  = rd_valid ? mem[rd_ptr][31:0]  : '0;
    assign rd.RD_LAST  = rd_valid && (count == CNT_ONE);
    assign STATE       = state;
    assign COUNT       = count;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed + random bench for mips_trace_buffer (DEPTH=8) against a queue-based trace model.
module tb_mips_trace_buffer;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET, ARM, STOP;
    logic [31:0] ADDRESS, DATA, TRIG_ADDR;
    logic [1:0]  STATE;
    logic [3:0]  COUNT;

    mips_trace_buffer_if rd_if ();

    mips_trace_buffer #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ADDRESS   (ADDRESS),
        .DATA      (DATA),
        .TRIG_ADDR (TRIG_ADDR),
        .ARM       (ARM),
        .STOP      (STOP),
        .rd        (rd_if),
        .STATE     (STATE),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    int          mstate = 0;     // 0 idle, 1 armed, 2 capture, 3 drain
    logic [63:0] q[$];           // captured entries, front = next to be read
    bit          dedup;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [63:0] s;
        s = {ADDRESS, DATA};
        if (RESET) begin
            mstate = 0;
            q.delete();
        end else begin
            case (mstate)
                0: if (ARM) begin mstate = 1; q.delete(); end
                1: begin
                    if (STOP) mstate = 0;
                    else if (ADDRESS == TRIG_ADDR) begin q.push_back(s); mstate = 2; end
                end
                2: begin
                    if (STOP) mstate = 3;
                    else begin
                        if (!(dedup && s == q[$])) q.push_back(s);
                        if (q.size() == DEPTH) mstate = 3;
                    end
                end
                default: begin
                    if (rd_if.RD_READY && q.size() != 0) begin
                        void'(q.pop_front());
                        if (q.size() == 0) mstate = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        logic        v;
        logic [63:0] head;
        v    = (mstate == 3) && (q.size() != 0);
        head = v ? q[0] : 64'd0;
        check("state",    64'(STATE),          64'(mstate));
        check("count",    64'(COUNT),          64'(q.size()));
        check("rd_valid", 64'(rd_if.RD_VALID), 64'(v));
        check("rd_pc",    64'(rd_if.RD_PC),    64'(head[63:32]));
        check("rd_data",  64'(rd_if.RD_DATA),  64'(head[31:0]));
        check("rd_last",  64'(rd_if.RD_LAST),  64'(v && q.size() == 1));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    // mode 0: RD_READY held high; mode 1: 1,0,0 repeating. A stray ARM is pulsed mid-drain.
    task automatic drain(input int mode);
        int n;
        n = 0;
        while (mstate != 0 && n < 64) begin
            rd_if.RD_READY = (mode == 0) ? 1'b1 : ((n % 3) == 0);
            ARM     = (n == 1);
            ADDRESS = $urandom;
            DATA    = $urandom;
            tick();
            n++;
        end
        ARM = 1'b0;
        rd_if.RD_READY = 1'b0;
        check("drain_done_state", 64'(STATE), 64'd0);
        check("drain_done_valid", 64'(rd_if.RD_VALID), 64'd0);
    endtask

    task automatic arm_pulse();
        ARM = 1'b1; ADDRESS = 32'h0; DATA = 32'h0;
        tick();
        ARM = 1'b0;
    endtask

    initial begin
`ifdef TRACE_DEDUP_EN
        dedup = 1'b1;
`else
        dedup = 1'b0;
`endif
        RESET = 1'b1; ARM = 1'b0; STOP = 1'b0;
        ADDRESS = 32'h0; DATA = 32'h0; TRIG_ADDR = 32'h3000;
        rd_if.RD_READY = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        check("reset_state", 64'(STATE), 64'd0);
        check("reset_count", 64'(COUNT), 64'd0);

        // Full capture: 0x2FFC does not match, 0x3000..0x301C fill all 8 entries
        arm_pulse();
        for (int i = 0; i < 9; i++) begin
            ADDRESS = 32'h2FFC + 32'(4 * i);
            DATA    = ADDRESS + 32'd1;
            ARM     = (i == 4);
            tick();
        end
        ARM = 1'b0;
        check("full_state", 64'(STATE), 64'd3);
        check("full_count", 64'(COUNT), 64'd8);
        check("full_first_pc", 64'(rd_if.RD_PC), 64'h3000);
        check("full_first_data", 64'(rd_if.RD_DATA), 64'h3001);
        drain(0);

        // STOP after three writes
        arm_pulse();
        for (int i = 0; i < 3; i++) begin
            ADDRESS = 32'h3000 + 32'(4 * i);
            DATA    = ADDRESS + 32'd1;
            tick();
        end
        STOP = 1'b1; ADDRESS = 32'h300C;
        tick();
        STOP = 1'b0;
        check("stop_state", 64'(STATE), 64'd3);
        check("stop_count", 64'(COUNT), 64'd3);
        drain(0);

        // Backpressure with random Results and a stray ARM during capture
        arm_pulse();
        for (int i = 0; i < 8; i++) begin
            ADDRESS = 32'h3000 + 32'(4 * i);
            DATA    = $urandom;
            ARM     = (i == 3);
            tick();
        end
        ARM = 1'b0;
        check("bp_state", 64'(STATE), 64'd3);
        drain(1);

        // STOP wins over a trigger match in ARMED
        arm_pulse();
        ADDRESS = 32'h3000; STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check("stop_armed_state", 64'(STATE), 64'd0);
        check("stop_armed_count", 64'(COUNT), 64'd0);

        // Self-loop at 0x3010 with an unchanging Result
        arm_pulse();
        ADDRESS = 32'h3000; DATA = 32'h1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ADDRESS = 32'h3010; DATA = 32'h7;
            tick();
        end
        check("dedup_count", 64'(COUNT), dedup ? 64'd2 : 64'd6);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        drain(0);

        // Reset out of DRAIN holding five entries
        arm_pulse();
        for (int i = 0; i < 5; i++) begin
            ADDRESS = 32'h3000 + 32'(4 * i);
            DATA    = ADDRESS + 32'd1;
            tick();
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check("pre_reset_count", 64'(COUNT), 64'd5);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("drain_reset_state", 64'(STATE), 64'd0);
        check("drain_reset_count", 64'(COUNT), 64'd0);
        check("drain_reset_valid", 64'(rd_if.RD_VALID), 64'd0);
        check("drain_reset_pc", 64'(rd_if.RD_PC), 64'd0);

        // Random control traffic; TRIG_ADDR changed only while idle
        TRIG_ADDR = 32'h3008;
        for (int i = 0; i < 600; i++) begin
            ARM            = ($urandom % 8) == 0;
            STOP           = ($urandom % 16) == 0;
            ADDRESS        = 32'h3000 + 32'(4 * $urandom_range(0, 7));
            DATA           = 32'($urandom_range(0, 3));
            rd_if.RD_READY = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
